btn_cmd_encoder: RTL and testbench

- Producer side of the reaction-timer command interface.
- Takes three raw, bouncy, asynchronous push-buttons (start, stop, clear).
- Synchronises and debounces each button, then detects press edges.
- Emits at most one single-cycle, one-hot command per clock, using the 3-bit encoding the timer consumes: START=001, STOP=010, CLEAR=100.
- Sits between the board buttons and the reaction timer's start/stop/clear inputs.

---
 rtl/rt_cmd_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 127 ++++++++++++
 rtl/btn_cmd_encoder.sv | 117 +++++++++++
 tb/tb_btn_cmd_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rt_cmd_pkg.sv
// -----------------------------------------------------------------------------
// rt_cmd_pkg
// Shared definitions for the reaction-timer command interface. Both the button
// command encoder (producer) and the reaction timer (consumer) import this
// package, so the one-hot command encoding is defined in exactly one place.
//
// Contents:
//   CMD_NONE / CMD_START / CMD_STOP / CMD_CLEAR : 3-bit one-hot command codes
//   db_state_t                                  : per-button debounce FSM states
//   cmd_priority()                              : press vector -> one-hot command
//   cmd_conflict()                              : more than one press this cycle
// -----------------------------------------------------------------------------
package rt_cmd_pkg;

  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b100;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  // Press vector is ordered {clear, stop, start}; START wins over STOP, which
  // wins over CLEAR. The result is always one-hot or zero.
  function automatic logic [2:0] cmd_priority(input logic [2:0] press);
    logic [2:0] sel;
    if (press[0]) begin
      sel = CMD_START;
    end else if (press[1]) begin
      sel = CMD_STOP;
    end else if (press[2]) begin
      sel = CMD_CLEAR;
    end else begin
      sel = CMD_NONE;
    end
    return sel;
  endfunction

  // True when at least two press edges coincide, i.e. some press is discarded.
  function automatic logic cmd_conflict(input logic [2:0] press);
    return (press[0] & (press[1] | press[2])) | (press[1] & press[2]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises one raw asynchronous push-button into the clk domain and
// debounces it. A level change is accepted only after DB_TICKS consecutive
// stable synchronised samples; any opposite sample during the wait abandons
// the change and returns to the previous stable state.
//
// Parameters:
//   DB_TICKS : consecutive stable samples needed (1 .. 2^DB_W-1)
//   DB_W     : debounce counter width
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   raw   in  raw button, active-high, asynchronous to clk
//   level out debounced, registered button level
// -----------------------------------------------------------------------------
module btn_debounce
  import rt_cmd_pkg::*;
#(
  parameter int unsigned DB_TICKS = 2_000_000,
  parameter int unsigned DB_W     = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  // The entry state already counts as the first stable sample, so the change
  // is accepted when the counter holds DB_TICKS-1 and one more agreeing
  // sample arrives. This puts the accepted level DB_TICKS edges after the
  // first synchronised sample.
  localparam logic [DB_W-1:0] LAST_CNT = DB_W'(DB_TICKS - 32'd1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(32'd1);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(32'd0);

  logic            r_sync1;
  logic            r_sync2;
  db_state_t       r_state;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with its stability counter and registered level output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOW;
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        LOW: begin
          if (r_sync2) begin
            // With a single required sample the change is accepted at once.
            if (LAST_CNT == CNT_ZERO) begin
              r_state <= HIGH;
              r_cnt   <= CNT_ZERO;
              r_level <= 1'b1;
            end else begin
              r_state <= WAIT_HIGH;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!r_sync2) begin
            r_state <= LOW;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt >= LAST_CNT) begin
            r_state <= HIGH;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b1;
          end else begin
            // Bounded by LAST_CNT, so the counter never wraps.
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!r_sync2) begin
            if (LAST_CNT == CNT_ZERO) begin
              r_state <= LOW;
              r_cnt   <= CNT_ZERO;
              r_level <= 1'b0;
            end else begin
              r_state <= WAIT_LOW;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          if (r_sync2) begin
            r_state <= HIGH;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt >= LAST_CNT) begin
            r_state <= LOW;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= CNT_ZERO;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;

endmodule

// File: rtl/btn_cmd_encoder.sv
// -----------------------------------------------------------------------------
// btn_cmd_encoder
// Producer side of the reaction-timer command interface. Three raw buttons
// (start, stop, clear) are synchronised and debounced, their rising debounced
// edges are detected, and at most one one-hot command pulse is emitted per
// clock with priority START > STOP > CLEAR. Losing press edges are discarded
// and flagged on dropped in the same cycle as the winning command.
//
// Parameters:
//   DB_TICKS : consecutive stable samples needed to accept a level change
//   DB_W     : debounce counter width
// Ports:
//   clk       in      system clock
//   rst       in      asynchronous active-low reset
//   btn_start in      raw start button (async, active-high)
//   btn_stop  in      raw stop button  (async, active-high)
//   btn_clear in      raw clear button (async, active-high)
//   cmd       out [3] one-hot command pulse: 001 start, 010 stop, 100 clear
//   cmd_valid out     high exactly when cmd is non-zero
//   held      out [3] debounced levels {clear, stop, start}
//   dropped   out     a press edge was discarded by priority this cycle
// -----------------------------------------------------------------------------
module btn_cmd_encoder
  import rt_cmd_pkg::*;
#(
  parameter int unsigned DB_TICKS = 2_000_000,
  parameter int unsigned DB_W     = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [2:0] held,
  output logic       dropped
);

  logic [2:0] w_level;
  logic [2:0] w_press;
  logic [2:0] w_cmd_next;
  logic       w_drop_next;
  logic [2:0] r_level_d;
  logic [2:0] r_cmd;
  logic       r_cmd_valid;
  logic       r_dropped;

  btn_debounce #(
    .DB_TICKS (DB_TICKS),
    .DB_W     (DB_W)
  ) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_start),
    .level (w_level[0])
  );

  btn_debounce #(
    .DB_TICKS (DB_TICKS),
    .DB_W     (DB_W)
  ) u_db_stop (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_stop),
    .level (w_level[1])
  );

  btn_debounce #(
    .DB_TICKS (DB_TICKS),
    .DB_W     (DB_W)
  ) u_db_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clear),
    .level (w_level[2])
  );

  // Previous debounced levels, used to find the cycle a level first rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level_d <= 3'b000;
    end else begin
      r_level_d <= w_level;
    end
  end

  // Press edges, priority selection and conflict detection.
  always_comb begin
    w_press     = 3'b000;
    w_cmd_next  = CMD_NONE;
    w_drop_next = 1'b0;
    w_press     = w_level & ~r_level_d;
    w_cmd_next  = cmd_priority(w_press);
    w_drop_next = cmd_conflict(w_press);
  end

  // Registered command outputs; a press edge yields a pulse exactly one cycle
  // later, and a held level produces no further edges so nothing repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd       <= CMD_NONE;
      r_cmd_valid <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_cmd       <= w_cmd_next;
      r_cmd_valid <= (w_cmd_next != CMD_NONE);
      r_dropped   <= w_drop_next;
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign held      = w_level;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// -----------------------------------------------------------------------------
// tb_btn_cmd_encoder
// Directed bench for btn_cmd_encoder with DB_TICKS=4, DB_W=3. Inputs are
// driven on the falling edge; outputs are sampled on the falling edge after
// each rising edge. Iteration i drives a value that is first sampled at the
// rising edge that follows, so a clean rise gives held at i=5 and cmd at i=6.
// -----------------------------------------------------------------------------
module tb_btn_cmd_encoder;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_clear;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [2:0] held;
  logic       dropped;

  int total;
  int bad;

  btn_cmd_encoder #(
    .DB_TICKS (4),
    .DB_W     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .held      (held),
    .dropped   (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outputs(input string name, input int i,
                               input logic [2:0] exp_cmd, input logic [2:0] exp_held,
                               input logic exp_drop);
    logic exp_v;
    exp_v = (exp_cmd != 3'b000);
    total++;
    if (cmd !== exp_cmd) begin
      bad++;
      $display("FAIL %s_cmd i=%0d got=%b exp=%b", name, i, cmd, exp_cmd);
    end
    total++;
    if (cmd_valid !== exp_v) begin
      bad++;
      $display("FAIL %s_valid i=%0d got=%b exp=%b", name, i, cmd_valid, exp_v);
    end
    total++;
    if (held !== exp_held) begin
      bad++;
      $display("FAIL %s_held i=%0d got=%b exp=%b", name, i, held, exp_held);
    end
    total++;
    if (dropped !== exp_drop) begin
      bad++;
      $display("FAIL %s_dropped i=%0d got=%b exp=%b", name, i, dropped, exp_drop);
    end
  endtask

  // Release all buttons and let the debouncers return to LOW; no commands.
  task automatic settle(input string name);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (cmd !== 3'b000) begin
        bad++;
        $display("FAIL %s_release_cmd i=%0d got=%b exp=000", name, i, cmd);
      end
    end
    total++;
    if (held !== 3'b000) begin
      bad++;
      $display("FAIL %s_release_held got=%b exp=000", name, held);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    btn_start = 1'b1;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_outputs("reset", i, 3'b000, 3'b000, 1'b0);
    end
    btn_start = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_outputs("post_reset", i, 3'b000, 3'b000, 1'b0);
    end
  endtask

  task automatic test_clean_press();
    btn_start = 1'b1;
    for (int i = 0; i < 31; i++) begin
      step();
      check_outputs("clean", i, (i == 6) ? 3'b001 : 3'b000,
                    (i >= 5) ? 3'b001 : 3'b000, 1'b0);
    end
    settle("clean");
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_stop = (i >= 4) || (i % 2 == 0);
      step();
      check_outputs("bounce", i, (i == 10) ? 3'b010 : 3'b000,
                    (i >= 9) ? 3'b010 : 3'b000, 1'b0);
    end
    // Release with single-cycle highs splitting the low runs into threes.
    for (int j = 0; j < 25; j++) begin
      btn_stop = (j == 3) || (j == 7);
      step();
      check_outputs("bounce_rel", j, 3'b000,
                    (j < 13) ? 3'b010 : 3'b000, 1'b0);
    end
    settle("bounce");
  endtask

  task automatic test_short_pulse();
    for (int i = 0; i < 15; i++) begin
      btn_clear = (i < 3);
      step();
      check_outputs("short", i, 3'b000, 3'b000, 1'b0);
    end
    settle("short");
  endtask

  task automatic test_simultaneous();
    btn_start = 1'b1;
    btn_clear = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check_outputs("simul", i, (i == 6) ? 3'b001 : 3'b000,
                    (i >= 5) ? 3'b101 : 3'b000, (i == 6));
    end
    settle("simul");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_held;
    logic [2:0] exp_cmd;
    for (int i = 0; i < 20; i++) begin
      btn_start = 1'b1;
      btn_stop  = (i >= 1);
      step();
      exp_held = {1'b0, (i >= 6), (i >= 5)};
      exp_cmd  = (i == 6) ? 3'b001 : ((i == 7) ? 3'b010 : 3'b000);
      check_outputs("stagger", i, exp_cmd, exp_held, 1'b0);
    end
    settle("stagger");
  endtask

  task automatic test_reset_mid_debounce();
    btn_stop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
    end
    total++;
    if (held !== 3'b010) begin
      bad++;
      $display("FAIL rmid_pre_held got=%b exp=010", held);
    end
    btn_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    // Mid-cycle reset, well away from any rising edge.
    #2;
    rst      = 1'b0;
    btn_stop = 1'b0;
    #1;
    check_outputs("rmid_async", 0, 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    step();
    check_outputs("rmid_hold", 0, 3'b000, 3'b000, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check_outputs("rmid", i, (i == 6) ? 3'b001 : 3'b000,
                    (i >= 5) ? 3'b001 : 3'b000, 1'b0);
    end
    settle("rmid");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_pulse();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
